// File: rtl/kyber_poly_reader_pkg.sv
// Shared types and constants for the Kyber coefficient RAM reader.
// Holds the polynomial size, coefficient type and the reader FSM encoding.
package kyber_pkg;

  localparam int KYBER_N = 256;
  localparam int COEF_W  = 12;

  typedef logic [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/kyber_poly_reader_if.sv
// Coefficient stream (valid/ready) between the RAM reader and the NTT stage.
interface kyber_poly_reader_if #(
  parameter int COEF_W = 12
);
  logic              m_valid;
  logic              m_ready;
  logic [COEF_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/kyber_poly_reader_fifo.sv
// Two-entry word FIFO that catches RAM read data one cycle after each issue.
module kyber_word_fifo #(
  parameter int WORD_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [WORD_W-1:0] i_data,
  output logic [WORD_W-1:0] o_data,
  output logic [1:0]        o_count
);
  logic [WORD_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) r_rptr <= ~r_rptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/kyber_poly_reader.sv
// Streams a range of 24-bit RAM words out as 12-bit coefficients (low half first),
// issuing reads only while the word FIFO plus the read in flight hold fewer than two words.
module kyber_poly_reader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 24,
  parameter int COEF_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [ADDR_W-1:0]   i_base_addr,
  input  logic [ADDR_W:0]     i_num_words,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_ram_ceb,
  output logic [ADDR_W-1:0]   o_ram_adb,
  input  logic [WORD_W-1:0]   i_ram_dout,
  kyber_poly_reader_if.master m_if
);
  import kyber_pkg::*;

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_issue_left;
  logic [ADDR_W:0]   r_pop_left;
  logic              r_inflight;
  logic              r_half;
  logic              r_busy;
  logic              r_done;

  logic [1:0]        w_count;
  logic [1:0]        w_credit;
  logic [WORD_W-1:0] w_head;
  logic              w_issue;
  logic              w_hs;
  logic              w_pop;

  kyber_word_fifo #(.WORD_W(WORD_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  (i_ram_dout),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign w_credit = w_count + {1'b0, r_inflight};
  assign w_issue  = (r_state == ST_RUN) && (r_issue_left != '0) && (w_credit < 2'd2);
  assign w_hs     = (w_count != 2'd0) && m_if.m_ready;
  assign w_pop    = w_hs && r_half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_pop_left   <= '0;
      r_inflight   <= 1'b0;
      r_half       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_addr       <= r_addr + ADDR_W'(1);
        r_issue_left <= r_issue_left - ONE_CNT;
      end
      if (w_hs)  r_half     <= ~r_half;
      if (w_pop) r_pop_left <= r_pop_left - ONE_CNT;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state      <= ST_RUN;
            r_busy       <= 1'b1;
            r_addr       <= i_base_addr;
            r_half       <= 1'b0;
            // A zero count means a full sweep of the RAM.
            r_issue_left <= (i_num_words == '0) ? FULL_CNT : i_num_words;
            r_pop_left   <= (i_num_words == '0) ? FULL_CNT : i_num_words;
          end
        end
        ST_RUN: begin
          if (w_issue && (r_issue_left == ONE_CNT)) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_pop && (r_pop_left == ONE_CNT)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_ram_ceb   = w_issue;
  assign o_ram_adb   = r_addr;
  assign m_if.m_valid = (w_count != 2'd0);
  assign m_if.m_data  = r_half ? w_head[WORD_W-1:COEF_W] : w_head[COEF_W-1:0];
  assign m_if.m_last  = r_half && (r_pop_left == ONE_CNT);
endmodule

// File: tb/tb_kyber_poly_reader.sv
// Scoreboard bench for kyber_poly_reader: expected coefficients and read addresses are
// queued at command issue and checked by a negedge monitor.
module tb_kyber_poly_reader;
  import kyber_pkg::*;

  typedef struct packed { coef_t data; logic last; } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  num_words = '0;
  logic        busy, done, ram_ceb;
  logic [7:0]  ram_adb;
  logic [23:0] ram_dout = '0;
  logic [23:0] mem [256];

  kyber_poly_reader_if #(.COEF_W(COEF_W)) m_if ();

  exp_t       exp_q[$];
  logic [7:0] addr_q[$];
  int n_checks = 0, n_fail = 0, n_rx = 0, issued = 0, popped = 0, rdy_mode = 0;
  logic  tb_half = 1'b0, prev_last = 1'b0, stall = 1'b0, stall_last = 1'b0;
  coef_t stall_data = '0;
  exp_t  e;

  kyber_poly_reader #(.ADDR_W(8), .WORD_W(24), .COEF_W(COEF_W)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_base_addr(base_addr),
    .i_num_words(num_words), .o_busy(busy), .o_done(done), .o_ram_ceb(ram_ceb),
    .o_ram_adb(ram_adb), .i_ram_dout(ram_dout), .m_if(m_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_ceb) ram_dout <= mem[ram_adb];

  initial begin
    m_if.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) m_if.m_ready = 1'b1;
      else m_if.m_ready = ($urandom_range(0, 99) < 30);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=timeout/empty required=event at %0t", nm, $time);
  endtask

  // Negedge monitor: handshakes, addresses, done, hold-under-backpressure, credit.
  always @(negedge clk) begin
    if (rst) begin
      prev_last = 1'b0; stall = 1'b0; tb_half = 1'b0; issued = 0; popped = 0;
    end else begin
      chk("done_pulse", done, prev_last);
      if (done) chk("busy_in_done", busy, 0);
      if (ram_ceb) begin
        issued++;
        if (addr_q.size() == 0) fail_now("unexpected_read");
        else chk("read_addr", ram_adb, addr_q.pop_front());
      end
      if (stall) begin
        chk("hold_valid", m_if.m_valid, 1);
        chk("hold_data", m_if.m_data, stall_data);
        chk("hold_last", m_if.m_last, stall_last);
      end
      prev_last = 1'b0;
      if (m_if.m_valid && m_if.m_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_coef");
        else begin
          e = exp_q.pop_front();
          chk("coef_data", m_if.m_data, e.data);
          chk("coef_last", m_if.m_last, e.last);
          prev_last = e.last;
        end
        n_rx++;
        if (tb_half) popped++;
        tb_half = ~tb_half;
      end
      stall      = m_if.m_valid && !m_if.m_ready;
      stall_data = m_if.m_data;
      stall_last = m_if.m_last;
      if (issued - popped > 2) chk("credit_limit", issued - popped, 2);
    end
  end

  task automatic push_cmd(input logic [7:0] b, input logic [8:0] n);
    int nn;
    logic [7:0] a;
    exp_t x;
    nn = (n == 0) ? 256 : int'(n);
    for (int i = 0; i < nn; i++) begin
      a = b + 8'(i);
      addr_q.push_back(a);
      x.data = {4'h0, a};       x.last = 1'b0;          exp_q.push_back(x);
      x.data = 12'h800 | {4'h0, a}; x.last = (i == nn - 1); exp_q.push_back(x);
    end
  endtask

  task automatic issue(input logic [7:0] b, input logic [8:0] n);
    push_cmd(b, n);
    base_addr = b; num_words = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, input int budget);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) fail_now("done_timeout");
    chk("queue_drained", exp_q.size(), 0);
  endtask

  int cyc, n0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {12'(i + 'h800), 12'(i)};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
    chk("rst_ceb", ram_ceb, 0);   chk("rst_adb", ram_adb, 0);
    chk("rst_valid", m_if.m_valid, 0); chk("rst_data", m_if.m_data, 0);
    chk("rst_last", m_if.m_last, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Latency with a single word.
    n0 = n_rx;
    issue(8'h05, 9'd1);
    chk("lat_ceb_T1", ram_ceb, 1); chk("lat_adb_T1", ram_adb, 8'h05); chk("lat_busy_T1", busy, 1);
    @(posedge clk); #1;
    chk("lat_valid_T2", m_if.m_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid_T3", m_if.m_valid, 1);
    wait_done(cyc, 50);
    chk("lat_coef_count", n_rx - n0, 2);

    // Full sweep, no backpressure, no bubbles.
    @(posedge clk); #1;
    n0 = n_rx;
    issue(8'h00, 9'd0);
    wait_done(cyc, 3000);
    chk("basic_cycles", cyc, 514);
    chk("basic_coef_count", n_rx - n0, 512);

    // Address wrap.
    n0 = n_rx;
    issue(8'hFE, 9'd4);
    wait_done(cyc, 100);
    chk("wrap_coef_count", n_rx - n0, 8);

    // Backpressure at ~30% ready.
    rdy_mode = 1;
    n0 = n_rx;
    issue(8'h30, 9'd16);
    wait_done(cyc, 3000);
    chk("bp_coef_count", n_rx - n0, 32);

    // Start during RUN ignored, then a start in the done cycle.
    issue(8'h10, 9'd8);
    repeat (2) @(posedge clk);
    #1;
    base_addr = 8'h80; num_words = 9'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, 1000);
    n0 = n_rx;
    issue(8'h90, 9'd3);
    wait_done(cyc, 1000);
    chk("b2b_coef_count", n_rx - n0, 6);

    // Reset in the middle of a 64-word command.
    rdy_mode = 0;
    n0 = n_rx;
    issue(8'h20, 9'd64);
    cyc = 0;
    while ((n_rx - n0) < 5 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if ((n_rx - n0) < 5) fail_now("mid_rst_wait");
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);     chk("mid_rst_done", done, 0);
    chk("mid_rst_ceb", ram_ceb, 0);   chk("mid_rst_adb", ram_adb, 0);
    chk("mid_rst_valid", m_if.m_valid, 0); chk("mid_rst_data", m_if.m_data, 0);
    chk("mid_rst_last", m_if.m_last, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n0 = n_rx;
    issue(8'h40, 9'd3);
    wait_done(cyc, 200);
    chk("post_rst_coef_count", n_rx - n0, 6);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/kyber_poly_reader.md
# kyber_poly_reader

Streaming read controller for the Kyber 256×24 coefficient block RAM. It sits directly downstream of the RAM's read port. On a start command it issues sequential reads and unpacks each 24-bit word into two 12-bit coefficients. It presents those coefficients as a valid/ready stream to the NTT/arithmetic stage, absorbing consumer backpressure without losing or repeating any word.

## Interface
Parameters:
- ADDR_W, 8, RAM address width (depth 2^ADDR_W words).
- WORD_W, 24, RAM data width; must equal 2*COEF_W.
- COEF_W, 12, coefficient width.

Ports:
- clk  in  1  single clock; drives this block and the RAM read port (clkb).
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle command; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; sampled with start.
- num_words  in  ADDR_W+1  word count, 1..2^ADDR_W; 0 is treated as 2^ADDR_W; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final coefficient handshake.
- ram_ceb  out  1  read enable to the RAM (ceb).
- ram_adb  out  ADDR_W  read address to the RAM (adb).
- ram_dout  in  WORD_W  RAM read data, valid the cycle after ram_ceb=1.
- m_valid  out  1  coefficient stream valid.
- m_ready  in  1  downstream ready.
- m_data  out  COEF_W  coefficient.
- m_last  out  1  marks the final coefficient of the command.

## Operation
- FSM states:
  - IDLE: start=1 latches base_addr/num_words, goes to RUN.
  - RUN: issues reads; after the last read is issued, goes to DRAIN.
  - DRAIN: waits for the last coefficient handshake, pulses done, goes to IDLE.
- start in RUN/DRAIN is ignored; no queuing.
- Read issue rule: ram_ceb=1 when in RUN, words remain to issue, and (fifo_count + inflight) < 2.
  - inflight is 1 in the cycle after an issue.
  - ram_adb increments by 1 per issue, modulo 2^ADDR_W: base 0xFF, count 3 reads 0xFF, 0x00, 0x01.
- ram_dout is written into the 2-entry word FIFO in the cycle after the issue, unconditionally; credit accounting guarantees space.
- Unpack order: coefficient ram_dout[COEF_W-1:0] first, then [WORD_W-1:COEF_W]. A half-select bit toggles on each handshake; the word is popped on the handshake of the high half.
- m_last=1 exactly when presenting the high half of the final word.
- m_valid/m_data/m_last hold steady while m_valid=1 and m_ready=0.
- Reset mid-operation: the FIFO empties, the FSM goes to IDLE, and in-flight RAM data is discarded. done is not pulsed.

## Timing
- Reset values: busy=0, done=0, ram_ceb=0, ram_adb=0, m_valid=0, m_data=0, m_last=0.
- start sampled at edge T0. busy=1 and the first ram_ceb=1 (adb=base) in cycle T1. ram_dout is valid in T2 and the FIFO is written at the end of T2. m_valid=1 from T3.
- Start-to-first-coefficient latency is 3 cycles.
- With m_ready held at 1, the stream sustains 1 coefficient per cycle with no bubbles after the first. Reads issue every other cycle in steady state.
- Final handshake at edge Tn: in cycle Tn+1, done=1, busy=0, and the state is IDLE. A start in Tn+1 is accepted.
- When m_ready=0 for long periods, reads stop once fifo_count+inflight=2. They resume the cycle after a word pop frees credit.

## Structure
- Shared package kyber_pkg holds:
  - constants KYBER_N=256 and COEF_W=12;
  - the FSM state enum (IDLE, RUN, DRAIN);
  - a coefficient typedef.
- Sub-module kyber_word_fifo: a 2-entry synchronous FIFO with WORD_W data, push/pop, count[1:0], and async active-high reset.
- Top level contains the FSM, address/issue counters, credit logic, and unpack mux.
- Target size is roughly 200 lines of RTL.

## Test plan
- Basic stream: RAM preloaded with word[i] = {i+0x800, i}; base=0, num_words=0 (256), m_ready=1.
  - 512 coefficients in order 0x000, 0x800, 0x001, 0x801, ….
  - m_last only on 0x8FF.
  - done pulses once, the cycle after the final handshake.
- Wrap-around: base=0xFE, num_words=4.
  - Reads of 0xFE, 0xFF, 0x00, 0x01 observed on ram_adb.
  - 8 coefficients, m_last on the 8th.
- Backpressure: random m_ready at 30% duty, num_words=16.
  - The received sequence equals the expected sequence exactly.
  - m_data is stable whenever m_valid=1 and m_ready=0.
  - fifo_count+inflight never exceeds 2.
- Ignored start and back-to-back commands: pulse start again during RUN → no effect. Then issue start in the done cycle → the second command completes correctly.
- Latency: start at T0 → ram_ceb at T1, m_valid at T3. A single word, num_words=1, gives exactly 2 coefficients.
- Reset mid-operation: assert rst after 5 coefficients of a 64-word command.
  - All outputs go to reset values immediately and no done pulse occurs.
  - A new command after release streams from its own base with no stale data.
